// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants and types for the register hazard scoreboard
package hazard_scoreboard_pkg;

    // Default geometry
    localparam int NREG_DEF   = 32;
    localparam int AW_DEF     = 5;
    localparam int CW_DEF     = 3;
    localparam int NSTAGE_DEF = 6;
    localparam int SW_DEF     = 32;

    // Stage bit positions inside the stall vector
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Stall encodings: id hazard freezes pc/if/id, ex busy additionally freezes ex
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'((1 << STG_PC) | (1 << STG_IF) | (1 << STG_ID));
    localparam logic [5:0] STALL_EX   = 6'((1 << STG_PC) | (1 << STG_IF) | (1 << STG_ID) | (1 << STG_EX));

    // Latency classes of common producers
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_LL   = 1;

    // Per-register counter operation chosen by the top each cycle
    typedef enum logic [1:0] {
        CELL_HOLD  = 2'd0,
        CELL_LOAD  = 2'd1,
        CELL_DRAIN = 2'd2
    } cell_op_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - id/ex hazard interface between pipeline and scoreboard
interface hazard_scoreboard_if #(
    parameter int AW     = 5,
    parameter int CW     = 3,
    parameter int NSTAGE = 6,
    parameter int SW     = 32
);
    logic              issue_valid;
    logic              issue_we;
    logic [AW-1:0]     issue_waddr;
    logic [CW-1:0]     issue_lat;
    logic              rs_re;
    logic [AW-1:0]     rs_addr;
    logic              rt_re;
    logic [AW-1:0]     rt_addr;
    logic              ex_stall_req;
    logic              flush;
    logic [NSTAGE-1:0] stall;
    logic              id_hazard;
    logic [AW:0]       pend_cnt;
    logic [SW-1:0]     stall_cycles;

    // Pipeline side
    modport master (
        output issue_valid, issue_we, issue_waddr, issue_lat,
        output rs_re, rs_addr, rt_re, rt_addr, ex_stall_req, flush,
        input  stall, id_hazard, pend_cnt, stall_cycles
    );

    // Scoreboard side
    modport slave (
        input  issue_valid, issue_we, issue_waddr, issue_lat,
        input  rs_re, rs_addr, rt_re, rt_addr, ex_stall_req, flush,
        output stall, id_hazard, pend_cnt, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard_sb_lat_cell.sv
// rtl/hazard_scoreboard_sb_lat_cell.sv - one register's pending-latency counter
module sb_lat_cell
    import hazard_scoreboard_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  cell_op_e      op,
    input  logic [CW-1:0] lat,
    output logic [CW-1:0] cnt_q,
    output logic [CW-1:0] cnt_d
);

    logic [CW-1:0] dec_v;

    // Next count: hold, drain toward zero, or take the larger of new latency and drained value
    always_comb begin
        dec_v = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        cnt_d = dec_v;
        case (op)
            CELL_HOLD:  cnt_d = cnt_q;
            CELL_LOAD:  cnt_d = (lat > dec_v) ? lat : dec_v;
            default:    cnt_d = dec_v;
        endcase
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register latency scoreboard driving the pipeline stall vector
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int AW     = AW_DEF,
    parameter int CW     = CW_DEF,
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int SW     = SW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    hazard_scoreboard_if.slave     bus
);

    logic [CW-1:0]     cnt_q [NREG];
    logic [CW-1:0]     cnt_d [NREG];
    logic              rs_hit;
    logic              rt_hit;
    logic              hazard;
    logic              accept;
    logic [NSTAGE-1:0] stall_v;
    logic [AW:0]       pend_cnt_d;
    logic [AW:0]       pend_cnt_q;
    logic [SW-1:0]     stall_cycles_d;
    logic [SW-1:0]     stall_cycles_q;

    // Register 0 never carries a pending result
    assign cnt_q[0] = '0;
    assign cnt_d[0] = '0;

    // Operand hazard: a read of a nonzero register whose result is still in flight
    always_comb begin
        rs_hit = bus.rs_re && (bus.rs_addr != '0) && (cnt_q[bus.rs_addr] != '0);
        rt_hit = bus.rt_re && (bus.rt_addr != '0) && (cnt_q[bus.rt_addr] != '0);
        hazard = rs_hit || rt_hit;
    end

    // Stall mux: ex busy dominates an id hazard
    always_comb begin
        stall_v = NSTAGE'(STALL_NONE);
        if (bus.ex_stall_req) begin
            stall_v = NSTAGE'(STALL_EX);
        end else if (hazard) begin
            stall_v = NSTAGE'(STALL_ID);
        end
    end

    // An issue only books its destination when id actually advances this cycle
    always_comb begin
        accept = bus.issue_valid && bus.issue_we && (bus.issue_waddr != '0)
                 && !hazard && !bus.ex_stall_req && !bus.flush;
    end

    for (genvar r = 1; r < NREG; r++) begin : g_cell
        cell_op_e op;

        // Back end frozen holds every counter; otherwise load the destination and drain the rest
        always_comb begin
            op = CELL_DRAIN;
            if (bus.ex_stall_req) begin
                op = CELL_HOLD;
            end else if (accept && (bus.issue_waddr == AW'(r))) begin
                op = CELL_LOAD;
            end
        end

        sb_lat_cell #(
            .CW (CW)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .op    (op),
            .lat   (bus.issue_lat),
            .cnt_q (cnt_q[r]),
            .cnt_d (cnt_d[r])
        );
    end

    // Population count of registers still pending after this cycle's update
    always_comb begin
        pend_cnt_d = '0;
        for (int r = 1; r < NREG; r++) begin
            pend_cnt_d = pend_cnt_d + (AW+1)'(cnt_d[r] != '0);
        end
    end

    // Saturating stalled-cycle counter
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((stall_v != '0) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + SW'(1);
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            pend_cnt_q     <= pend_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall        = stall_v;
    assign bus.id_hazard    = hazard;
    assign bus.pend_cnt     = pend_cnt_q;
    assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-slot load-use interlock between id and ex.
- Keeps one pending-latency counter per architectural register.
- Stalls id while any source operand it reads is still in flight from a load or other multi-cycle producer.
- Merges the ex multi-cycle stall request and drives the pipeline stall vector consumed by pc_reg, pc_id, id_ex, ex_mem and wb; also keeps hazard statistics.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width; equals clog2(NREG).
- CW, 3, latency field and counter width; max latency 2^CW-1.
- NSTAGE, 6, stall vector width: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
- SW, 32, width of stall statistics counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction in id is a real (non-bubble) instruction
- issue_we  in  1  that instruction writes a GPR
- issue_waddr  in  AW  destination register
- issue_lat  in  CW  cycles the result is unforwardable after leaving id; 0 = ALU result, forwardable via ex/mem bypass
- rs_re  in  1  id reads rs
- rs_addr  in  AW  rs index
- rt_re  in  1  id reads rt
- rt_addr  in  AW  rt index
- ex_stall_req  in  1  ex multi-cycle operation (madd/div) not finished
- flush  in  1  kill the instruction in id this cycle
- stall  out  NSTAGE  pipeline stall vector
- id_hazard  out  1  id operand hazard detected (combinational)
- pend_cnt  out  AW+1  number of registers with nonzero counter (registered)
- stall_cycles  out  SW  saturating count of cycles with stall!=0

Behaviour:
- State: cnt[r], CW bits, r=1..NREG-1; cnt[0] is constant 0.
- Reset (async, active-high): all cnt=0, pend_cnt=0, stall_cycles=0; stall=0 and id_hazard=0 follow combinationally.
- id_hazard = (rs_re & rs_addr!=0 & cnt[rs_addr]!=0) | (rt_re & rt_addr!=0 & cnt[rt_addr]!=0).
- stall priority: ex_stall_req -> 6'b001111; else id_hazard -> 6'b000111; else 0.
- stall is combinational from registered state plus ex_stall_req; this path is zero-latency.
- accept = issue_valid & issue_we & issue_waddr!=0 & !id_hazard & !ex_stall_req & !flush.
- Counter update each clock, per register:
  - if ex_stall_req: hold all counters, because back end frozen ahead of ex (id_ex holds).
  - else if accept & r==issue_waddr: cnt <= max(issue_lat, dec(cnt)).
  - else: cnt <= dec(cnt), where dec(x) = x==0 ? 0 : x-1.
- Latency semantics:
  - Instruction accepted at cycle T with lat L: a reader in id at T+1..T+L stalls.
  - Reader proceeds at T+L+1.
  - L=1 gives the classic one-cycle load-use bubble.
  - L=0 never stalls.
- Same-register reissue (WAW): never shortens a pending counter (max rule).
- flush: suppresses the current issue only; counters of older in-flight instructions keep draining.
- Reader equal to issuing writer in the same cycle: no self-hazard; the counter is visible from the next cycle.
- id_hazard with issue_valid=1: issue is not accepted; id re-presents the same instruction next cycle.
- pend_cnt: registered population count of nonzero counters after update, range 0..NREG-1.
- stall_cycles: increments when stall!=0; saturates at all-ones; no wrap.
- Reset mid-operation: all pending state cleared immediately; no stall asserted after reset releases.

Decomposition:
- Shared package:
  - stall vector encodings: STALL_NONE, STALL_ID=6'b000111, STALL_EX=6'b001111.
  - stage bit index constants.
  - latency class constants: LAT_ALU=0, LAT_LOAD=1, LAT_LL=1.
- One natural sub-module: sb_lat_cell, one register's counter with load/decrement/hold/max logic, instantiated NREG-1 times via generate.
- Hazard compare, stall mux and statistics stay in the top.

Test Plan:
- Load-use: accept lw $3 lat=1 at T; at T+1 rs_re=1 rs_addr=3 -> stall=6'b000111 for exactly 1 cycle, 0 at T+2, pend_cnt 1 then 0.
- Long latency: accept waddr=5 lat=3; rt reads 5 -> id_hazard for 3 cycles; stall_cycles increases by 3.
- WAW: cnt[7]=3; next cycle accept waddr=7 lat=1 -> cnt[7]=2 (max rule), not 1; then lat=5 -> 5.
- EX stall: cnt[4]=2 and ex_stall_req=1 for 4 cycles -> stall=6'b001111, cnt[4] holds 2; after release, drains 2 -> 1 -> 0.
- Zero register and flush: accept to waddr=0 lat=3 -> no pending; issue waddr=9 lat=2 with flush=1 -> cnt[9] stays 0, no later stall.
- Async reset with cnt[3]=2 asserted between edges -> stall, id_hazard, pend_cnt drop to 0 immediately; stall_cycles=0.
